stream_frame_sequencer: RTL and testbench

//  Front-end controller for stream_neural_net: turns VSYNC/HSYNC-framed pixel stream into indexed, validated pixel beats.

---
 rtl/nn_stream_pkg.sv | 10 +
 rtl/sync_edge_det.sv | 15 +
 rtl/stream_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_stream_frame_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_stream_pkg.sv
// nn_stream_pkg: shared sequencer state type, default geometry and index-width helper
package nn_stream_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, COMPUTE} seq_state_t;
  localparam int DATA_W_DEF = 16;
  localparam int COLS_DEF = 28;
  localparam int ROWS_DEF = 28;
  function automatic int IDX_W(input int cols, input int rows);
    return (cols * rows > 1) ? $clog2(cols * rows) : 1;
  endfunction
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registers a sync level and flags its edges; register resets high so a level held at reset release is not an edge
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);
  logic q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b1;
    else q <= sig;
  assign rise = sig & ~q;
  assign fall = ~sig & q;
endmodule

// File: rtl/stream_frame_sequencer.sv
// stream_frame_sequencer: VSYNC/HSYNC framed pixels to indexed beats, frame checks, result hand-off.
// Define SEQ_TIMEOUT_EN to add the COMPUTE timeout counter, TIMEOUT parameter and timeout port.
module stream_frame_sequencer
  import nn_stream_pkg::*;
#(
  parameter int dataWidth = DATA_W_DEF,
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int RES_W = 4,
`ifdef SEQ_TIMEOUT_EN
  parameter int TIMEOUT = 4096,
`endif
  localparam int IW = IDX_W(COLS, ROWS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 VSYNC,
  input  logic                 HSYNC,
  input  logic [dataWidth-1:0] pix_in,
  output logic [dataWidth-1:0] pix_out,
  output logic                 pix_valid,
  output logic [IW-1:0]        pix_idx,
  output logic                 frame_start,
  output logic                 frame_end,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  input  logic                 net_done,
  input  logic [RES_W-1:0]     net_result,
  output logic [RES_W-1:0]     result,
  output logic                 result_valid
`ifdef SEQ_TIMEOUT_EN
  ,
  output logic                 timeout
`endif
);
  localparam int CW = $clog2(COLS + 1);
  localparam int RW = $clog2(ROWS + 1);
  localparam logic [CW-1:0] COLS_C = CW'(COLS);
  localparam logic [RW-1:0] ROWS_C = RW'(ROWS);
  seq_state_t state, state_n;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic err, err_n, accept;
  logic fe_n, ferr_n, ovr_n, rv_n;
  logic [RES_W-1:0] result_n;
  logic vs_rise, vs_fall, hs_rise, hs_fall;
  logic unused_hs;
  sync_edge_det u_vs (.clk(clk), .rst_n(rst_n), .sig(VSYNC), .rise(vs_rise), .fall(vs_fall));
  sync_edge_det u_hs (.clk(clk), .rst_n(rst_n), .sig(HSYNC), .rise(hs_rise), .fall(hs_fall));
  assign unused_hs = hs_rise;
  assign busy = state != IDLE;
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  logic to_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt <= '0;
      timeout <= 1'b0;
    end else begin
      tcnt <= state == COMPUTE ? tcnt + TW'(1) : '0;
      timeout <= to_n;
    end
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    col_n = col;
    row_n = row;
    err_n = err;
    accept = 1'b0;
    fe_n = 1'b0;
    ferr_n = 1'b0;
    ovr_n = 1'b0;
    rv_n = 1'b0;
    result_n = result;
`ifdef SEQ_TIMEOUT_EN
    to_n = 1'b0;
`endif
    case (state)
      IDLE:
        if (vs_rise) begin
          state_n = ACTIVE;
          col_n = '0;
          row_n = '0;
          err_n = 1'b0;
        end
      ACTIVE: begin
        if (VSYNC && HSYNC) begin
          if (col < COLS_C) begin
            accept = 1'b1;
            col_n = col + CW'(1);
          end else err_n = 1'b1;
        end
        // line closes before the frame is judged when both syncs drop together
        if (hs_fall) begin
          if (col != COLS_C || row == ROWS_C) err_n = 1'b1;
          row_n = row == ROWS_C ? row : row + RW'(1);
          col_n = '0;
        end
        if (vs_fall) begin
          if (row_n == ROWS_C && !err_n) begin
            state_n = COMPUTE;
            fe_n = 1'b1;
          end else begin
            state_n = IDLE;
            ferr_n = 1'b1;
          end
        end
      end
      COMPUTE: begin
        ovr_n = vs_rise;
        if (net_done) begin
          state_n = IDLE;
          result_n = net_result;
          rv_n = 1'b1;
        end
`ifdef SEQ_TIMEOUT_EN
        else if (tcnt == TW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          ferr_n = 1'b1;
          to_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      col <= '0;
      row <= '0;
      err <= 1'b0;
      pix_out <= '0;
      pix_valid <= 1'b0;
      pix_idx <= '0;
      frame_start <= 1'b0;
      frame_end <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      result <= '0;
      result_valid <= 1'b0;
    end else begin
      col <= col_n;
      row <= row_n;
      err <= err_n;
      pix_valid <= accept;
      if (accept) begin
        pix_out <= pix_in;
        pix_idx <= IW'(row) * IW'(COLS) + IW'(col);
      end
      frame_start <= accept && row == '0 && col == '0;
      frame_end <= fe_n;
      frame_err <= ferr_n;
      overrun <= ovr_n;
      result <= result_n;
      result_valid <= rv_n;
    end
endmodule

// File: tb/tb_stream_frame_sequencer.sv
// tb_stream_frame_sequencer: frame-descriptor driven bench; expected outputs per cycle derived from frame geometry
module tb_stream_frame_sequencer;
  localparam int COLS = 28;
  localparam int ROWS = 28;
  localparam int MAXC = 60000;
  localparam int TO = 64;
  logic clk, rst_n, VSYNC, HSYNC, net_done;
  logic [15:0] pix_in, pix_out;
  logic pix_valid, frame_start, frame_end, frame_err, overrun, busy, result_valid;
  logic [9:0] pix_idx;
  logic [3:0] net_result, result;
`ifdef SEQ_TIMEOUT_EN
  logic timeout;
  bit e_to [MAXC];
  int to_pc = 0;
`endif
  stream_frame_sequencer #(.dataWidth(16), .COLS(COLS), .ROWS(ROWS), .RES_W(4)
`ifdef SEQ_TIMEOUT_EN
    , .TIMEOUT(TO)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .VSYNC(VSYNC), .HSYNC(HSYNC), .pix_in(pix_in),
    .pix_out(pix_out), .pix_valid(pix_valid), .pix_idx(pix_idx),
    .frame_start(frame_start), .frame_end(frame_end), .frame_err(frame_err),
    .overrun(overrun), .busy(busy), .net_done(net_done), .net_result(net_result),
    .result(result), .result_valid(result_valid)
`ifdef SEQ_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int pc = 0;
  always @(posedge clk) pc <= pc + 1;
  bit e_valid [MAXC], e_fs [MAXC], e_fe [MAXC], e_ferr [MAXC], e_ovr [MAXC], e_rv [MAXC], e_busy [MAXC];
  int e_idx [MAXC];
  bit [15:0] e_pix [MAXC];
  bit [3:0] e_res [MAXC];
  bit m_busy, m_compute, chk_en;
  bit [3:0] m_res;
  int m_ce = -1000;
  int slot;
  int lens [0:63];
  int total = 0, bad = 0;
  int n_valid = 0, n_fs = 0, n_fe = 0, n_ferr = 0, n_ovr = 0, n_rv = 0, last_idx = -1, fe_pc = 0;
  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, pc);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en && pc < MAXC) begin
      chk("pix_valid", int'(pix_valid), int'(e_valid[pc]));
      if (e_valid[pc]) begin
        chk("pix_idx", int'(pix_idx), e_idx[pc]);
        chk("pix_out", int'(pix_out), int'(e_pix[pc]));
      end
      chk("frame_start", int'(frame_start), int'(e_fs[pc]));
      chk("frame_end", int'(frame_end), int'(e_fe[pc]));
      chk("frame_err", int'(frame_err), int'(e_ferr[pc]));
      chk("overrun", int'(overrun), int'(e_ovr[pc]));
      chk("result_valid", int'(result_valid), int'(e_rv[pc]));
      chk("result", int'(result), int'(e_res[pc]));
      chk("busy", int'(busy), int'(e_busy[pc]));
`ifdef SEQ_TIMEOUT_EN
      chk("timeout", int'(timeout), int'(e_to[pc]));
      if (timeout) to_pc = pc;
`endif
      n_valid += int'(pix_valid);
      n_fs += int'(frame_start);
      n_fe += int'(frame_end);
      n_ferr += int'(frame_err);
      n_ovr += int'(overrun);
      n_rv += int'(result_valid);
      if (pix_valid) last_idx = int'(pix_idx);
      if (frame_end) fe_pc = pc;
    end
  end
  // drive one cycle; expectations for the edge that samples these inputs land in slot
  task automatic step(input bit v, input bit h, input bit nd, input logic [15:0] p, input logic [3:0] nr);
    @(negedge clk);
    VSYNC = v;
    HSYNC = h;
    net_done = nd;
    pix_in = p;
    net_result = nr;
    slot = pc + 1;
    if (m_compute) begin
      if (nd) begin
        m_compute = 0;
        m_busy = 0;
        m_res = nr;
        e_rv[slot] = 1;
      end
`ifdef SEQ_TIMEOUT_EN
      else if (slot == m_ce + TO) begin
        m_compute = 0;
        m_busy = 0;
        e_ferr[slot] = 1;
        e_to[slot] = 1;
      end
`endif
    end
    e_busy[slot] = m_busy;
    e_res[slot] = m_res;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask
  task automatic clr(input int s);
    e_valid[s] = 0; e_fs[s] = 0; e_fe[s] = 0; e_ferr[s] = 0; e_ovr[s] = 0;
    e_rv[s] = 0; e_busy[s] = 0; e_res[s] = 0;
`ifdef SEQ_TIMEOUT_EN
    e_to[s] = 0;
`endif
  endtask
  task automatic fill_good();
    for (int i = 0; i < 64; i++) lens[i] = COLS;
  endtask
  // a frame is good only with exactly ROWS lines of exactly COLS pixels
  task automatic run_frame(input int nl, input int gap, input int tail, input int pre,
                           input bit done_rise, input bit [3:0] dres, input int rst_at);
    bit good, acc;
    int k, rr;
    logic [15:0] p;
    good = (nl == ROWS);
    for (int i = 0; i < nl; i++) if (lens[i] != COLS) good = 0;
    idle(pre);
    acc = !m_busy;
    step(1, 0, done_rise, 0, dres);
    if (acc) begin
      m_busy = 1;
      e_busy[slot] = 1;
    end else e_ovr[slot] = 1;
    for (int i = 0; i < gap; i++) step(1, 0, 0, 0, 0);
    k = 0;
    for (int r = 0; r < nl; r++) begin
      rr = r < ROWS ? r : ROWS;
      for (int j = 0; j < lens[r]; j++) begin
        p = 16'($urandom);
        step(1, 1, 0, p, 0);
        if (acc && j < COLS) begin
          e_valid[slot] = 1;
          e_idx[slot] = (rr * COLS + j) & 1023;
          e_pix[slot] = p;
          e_fs[slot] = (r == 0 && j == 0);
        end
        k++;
        if (k == rst_at) begin
          #2 rst_n = 0;
          acc = 0; m_busy = 0; m_compute = 0; m_res = 0;
          clr(slot);
          #1;
          chk("arst_valid", int'(pix_valid), 0);
          chk("arst_busy", int'(busy), 0);
          chk("arst_result", int'(result), 0);
        end
        if (k == rst_at + 5) #2 rst_n = 1;
      end
      for (int i = 0; i < ((r == nl - 1) ? tail : gap); i++) step(1, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 0);
    if (acc) begin
      if (good) begin
        m_compute = 1;
        m_ce = slot;
        e_fe[slot] = 1;
      end else begin
        m_busy = 0;
        e_busy[slot] = 0;
        e_ferr[slot] = 1;
      end
    end
  endtask
  task automatic do_done(input int dly, input bit [3:0] r);
    idle(dly);
    step(0, 0, 1, 0, r);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog expired cycle=%0d", pc);
    $fatal(1, "watchdog");
  end
  initial begin
    int s_valid, s_fs, s_fe, s_ferr, s_ovr, s_rv, kind, nl;
    rst_n = 0; VSYNC = 0; HSYNC = 0; pix_in = 0; net_done = 0; net_result = 0;
    m_busy = 0; m_compute = 0; m_res = 0;
    step(0, 0, 0, 0, 0);
    chk_en = 1;
    idle(3);
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_valid", int'(pix_valid), 0);
    #1 rst_n = 1;
    idle(2);
    // nominal frame then result three cycles after frame_end
    fill_good();
    s_valid = n_valid; s_fs = n_fs; s_fe = n_fe; s_rv = n_rv;
    run_frame(ROWS, 4, 4, 5, 0, 0, -1);
    do_done(2, 4'd7);
    idle(2);
    chk("nom_pixels", n_valid - s_valid, 784);
    chk("nom_last_idx", last_idx, 783);
    chk("nom_starts", n_fs - s_fs, 1);
    chk("nom_ends", n_fe - s_fe, 1);
    chk("nom_rv", n_rv - s_rv, 1);
    chk("nom_result", int'(result), 7);
    chk("nom_busy", int'(busy), 0);
    // line 5 short by one pixel
    fill_good();
    lens[5] = COLS - 1;
    s_ferr = n_ferr; s_fe = n_fe;
    run_frame(ROWS, 4, 4, 5, 0, 0, -1);
    idle(2);
    chk("short_err", n_ferr - s_ferr, 1);
    chk("short_end", n_fe - s_fe, 0);
    s_rv = n_rv;
    do_done(0, 4'd3);
    idle(2);
    chk("stray_done_rv", n_rv - s_rv, 0);
    chk("stray_done_result", int'(result), 7);
    // frame arriving during COMPUTE is dropped
    fill_good();
    run_frame(ROWS, 2, 2, 3, 0, 0, -1);
    s_valid = n_valid; s_ovr = n_ovr;
    run_frame(3, 2, 2, 2, 0, 0, -1);
    idle(2);
    chk("ovr_pulse", n_ovr - s_ovr, 1);
    chk("ovr_pixels", n_valid - s_valid, 0);
    do_done(1, 4'd9);
    fill_good();
    s_valid = n_valid;
    run_frame(ROWS, 3, 0, 3, 0, 0, -1);
    do_done(1, 4'd5);
    idle(2);
    chk("after_ovr_pixels", n_valid - s_valid, 784);
    // async reset mid-frame with VSYNC held high
    s_fs = n_fs; s_ferr = n_ferr;
    run_frame(ROWS, 2, 2, 3, 0, 0, 300);
    idle(2);
    chk("arst_no_err", n_ferr - s_ferr, 0);
    chk("arst_one_start", n_fs - s_fs, 1);
    s_fs = n_fs;
    run_frame(ROWS, 2, 2, 3, 0, 0, -1);
    do_done(0, 4'd2);
    idle(2);
    chk("arst_next_start", n_fs - s_fs, 1);
    // randomized frames, some dropped as overruns, done sometimes coinciding with a rise
    for (int it = 0; it < 10; it++) begin
      fill_good();
      nl = ROWS;
      kind = $urandom_range(0, 5);
      if (kind == 3) lens[$urandom_range(0, ROWS - 1)] = $urandom_range(1, COLS - 1);
      if (kind == 4) lens[$urandom_range(0, ROWS - 1)] = COLS + $urandom_range(1, 2);
      if (kind == 5) nl = $urandom_range(0, 1) ? ROWS - 1 : ROWS + 1;
      run_frame(nl, $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(1, 6), 0, 0, -1);
      if ($urandom_range(0, 2) == 0) begin
        fill_good();
        run_frame($urandom_range(1, 3), 1, 1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 4'($urandom), -1);
      end
      do_done($urandom_range(0, 5), 4'($urandom));
      idle(1);
    end
`ifdef SEQ_TIMEOUT_EN
    fill_good();
    s_ferr = n_ferr;
    run_frame(ROWS, 2, 2, 3, 0, 0, -1);
    idle(TO + 6);
    chk("to_delay", to_pc - fe_pc, TO);
    chk("to_err", n_ferr - s_ferr, 1);
    chk("to_result_held", int'(result), int'(m_res));
`endif
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
